// File: rtl/pss_timing_tracker.sv
// PSS timing tracker: acquires the PSS peak period from the peak-detector flag,
// confirms it over several periods, then predicts SSB starts and reports peak timing offsets.
module pss_timing_tracker #(
    parameter int PERIOD_LEN = 38400,
    parameter int TOLERANCE  = 4,
    parameter int LOCK_COUNT = 3,
    parameter int MISS_LIMIT = 2,
    parameter int OFFSET_DW  = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 s_axis_in_tvalid,
    input  logic                 peak_detected_i,
    input  logic                 enable_i,
    output logic                 locked_o,
    output logic                 ssb_start_o,
    output logic [OFFSET_DW-1:0] timing_offset_o,
    output logic                 offset_valid_o,
    output logic [1:0]           state_o
);

    localparam int CNT_W  = $clog2(PERIOD_LEN + TOLERANCE + 1);
    localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(PERIOD_LEN - TOLERANCE);
    localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(PERIOD_LEN + TOLERANCE);
    localparam logic [CNT_W-1:0] PRED_CNT = CNT_W'(PERIOD_LEN);
    localparam logic [CNT_W-1:0] FREE_RUN = CNT_W'(TOLERANCE + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (TOLERANCE >= PERIOD_LEN / 2) begin : g_bad_tolerance
        $error("TOLERANCE must be less than PERIOD_LEN/2");
    end
    if (OFFSET_DW < $clog2(TOLERANCE + 1) + 1) begin : g_bad_offset_dw
        $error("OFFSET_DW too narrow for +/-TOLERANCE");
    end
    if (LOCK_COUNT < 1 || MISS_LIMIT < 1) begin : g_bad_counts
        $error("LOCK_COUNT and MISS_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [HIT_W-1:0]   hits_reg;
    logic [MISS_W-1:0]  misses_reg;

    logic               in_window;
    logic               at_close;
    logic               at_pred;
    logic [HIT_W-1:0]   hits_inc;
    logic [MISS_W-1:0]  misses_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic [OFFSET_DW-1:0] offset_next;

    assign in_window   = (cnt_reg >= WIN_LO) && (cnt_reg <= WIN_HI);
    assign at_close    = (cnt_reg == WIN_HI);
    assign at_pred     = (cnt_reg == PRED_CNT);
    assign hits_inc    = hits_reg + HIT_W'(1);
    assign misses_inc  = misses_reg + MISS_W'(1);
    assign cnt_inc     = cnt_reg + CNT_ONE;
    // Only evaluated inside the window, so the difference always fits OFFSET_DW.
    assign offset_next = OFFSET_DW'(int'(cnt_reg) - PERIOD_LEN);
    assign state_o     = state_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i || !enable_i) begin
            state_reg       <= SEARCH;
            cnt_reg         <= '0;
            hits_reg        <= '0;
            misses_reg      <= '0;
            locked_o        <= 1'b0;
            ssb_start_o     <= 1'b0;
            offset_valid_o  <= 1'b0;
            timing_offset_o <= '0;
        end else begin
            ssb_start_o    <= 1'b0;
            offset_valid_o <= 1'b0;
            if (s_axis_in_tvalid) begin
                case (state_reg)
                    SEARCH: begin
                        if (peak_detected_i) begin
                            cnt_reg  <= CNT_ONE;
                            hits_reg <= HIT_W'(1);
                            if (LOCK_COUNT == 1) begin
                                state_reg  <= LOCKED;
                                locked_o   <= 1'b1;
                                misses_reg <= '0;
                            end else begin
                                state_reg <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (peak_detected_i && in_window) begin
                            cnt_reg  <= CNT_ONE;
                            hits_reg <= hits_inc;
                            if (hits_inc == HIT_W'(LOCK_COUNT)) begin
                                state_reg  <= LOCKED;
                                locked_o   <= 1'b1;
                                misses_reg <= '0;
                            end
                        end else if (at_close) begin
                            state_reg <= SEARCH;
                            cnt_reg   <= '0;
                            hits_reg  <= '0;
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end
                    LOCKED: begin
                        if (at_pred) begin
                            ssb_start_o <= 1'b1;
                        end
                        if (peak_detected_i && in_window) begin
                            cnt_reg         <= CNT_ONE;
                            misses_reg      <= '0;
                            timing_offset_o <= offset_next;
                            offset_valid_o  <= 1'b1;
                        end else if (at_close) begin
                            if (misses_inc == MISS_W'(MISS_LIMIT)) begin
                                state_reg  <= SEARCH;
                                locked_o   <= 1'b0;
                                cnt_reg    <= '0;
                                hits_reg   <= '0;
                                misses_reg <= '0;
                            end else begin
                                // Keep predicting as if the missed peak had landed on time.
                                misses_reg <= misses_inc;
                                cnt_reg    <= FREE_RUN;
                            end
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end
                    default: begin
                        state_reg <= SEARCH;
                        locked_o  <= 1'b0;
                        cnt_reg   <= '0;
                        hits_reg  <= '0;
                        misses_reg <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pss_timing_tracker.md
Name: pss_timing_tracker

Overview:
- Sits directly downstream of the PSS correlator/peak-detector stage and consumes its per-sample peak flag.
- Acquires the PSS period, confirms it over several periods, then locks. While locked it emits a predicted SSB-start strobe every period and reports each measured peak's timing offset against the prediction.
- Declares loss of lock after consecutive missed peaks.
- Its outputs drive the downstream FFT/symbol-timing and frame-sync logic.

Parameters:
- PERIOD_LEN, 38400: samples between successive PSS peaks (20 ms at 1.92 MSps).
- TOLERANCE, 4: half-width of the acceptance window around the predicted peak, in samples.
- LOCK_COUNT, 3: consecutive in-window peaks, including the first, needed to reach LOCKED.
- MISS_LIMIT, 2: consecutive missed windows in LOCKED that force a return to SEARCH.
- OFFSET_DW, 8: width of the signed timing-offset output.
- Localparam CNT_W: $clog2(PERIOD_LEN+TOLERANCE+1).

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: synchronous, active-high reset.
- s_axis_in_tvalid, input, 1: sample strobe aligned with peak_detected_i.
- peak_detected_i, input, 1: peak flag from the peak detector. Only meaningful when s_axis_in_tvalid=1.
- enable_i, input, 1: tracker enable. Low acts as a synchronous clear.
- locked_o, output, 1: high while the state is LOCKED.
- ssb_start_o, output, 1: one-cycle pulse at the predicted peak sample while LOCKED.
- timing_offset_o, output, OFFSET_DW: signed (peak cnt − PERIOD_LEN). Holds its value until the next update.
- offset_valid_o, output, 1: one-cycle pulse when timing_offset_o updates.
- state_o, output, 2: state encoding. 0 = SEARCH, 1 = VERIFY, 2 = LOCKED.

Behaviour:
- Reset (reset_i=1) or enable_i=0 at a clock edge:
  - state goes to SEARCH; cnt=0, hits=0, misses=0.
  - All outputs go to 0, including timing_offset_o.
  - reset_i takes priority over everything else.
- Sample evaluation:
  - Everything advances only on cycles with s_axis_in_tvalid=1. Cycles with tvalid=0 hold all state, and the pulse outputs deassert.
  - Each valid sample is evaluated against the current cnt value c. "Window" means PERIOD_LEN−TOLERANCE ≤ c ≤ PERIOD_LEN+TOLERANCE.
- Output timing: all outputs are registered and assert on the clock edge that consumes the qualifying sample, i.e. they are visible the cycle after the sample is presented.
- SEARCH:
  - cnt is held at 0.
  - On a peak: next cnt=1, hits=1, go to VERIFY. If LOCK_COUNT=1, go directly to LOCKED.
- VERIFY:
  - Peak inside the window: next cnt=1 (realign), hits+1. If hits reaches LOCK_COUNT, go to LOCKED with misses=0.
  - Peak outside the window: ignored.
  - c = PERIOD_LEN+TOLERANCE with no peak: go to SEARCH, cnt=0, hits=0.
  - Otherwise: cnt+1.
- LOCKED:
  - locked_o=1.
  - c = PERIOD_LEN: ssb_start_o pulses, whether or not a peak is present.
  - Peak inside the window:
    - next cnt=1 and misses=0.
    - timing_offset_o = c − PERIOD_LEN, sign-extended; offset_valid_o pulses.
  - Peak outside the window: ignored.
  - c = PERIOD_LEN+TOLERANCE with no peak: misses+1 and next cnt = TOLERANCE+1, so the prediction free-runs.
    - If misses reaches MISS_LIMIT: go to SEARCH, cnt=0, hits=0, misses=0; locked_o drops on the same edge.
- Boundary conditions:
  - A peak at exactly c = PERIOD_LEN±TOLERANCE is a hit.
  - A peak coinciding with window close counts as a hit, not a miss.
  - On the LOCKED entry edge, locked_o rises and no offset is reported.
  - cnt never exceeds PERIOD_LEN+TOLERANCE.
  - Peaks on tvalid=0 cycles are ignored.
- Elaboration checks:
  - TOLERANCE < PERIOD_LEN/2.
  - OFFSET_DW ≥ $clog2(TOLERANCE+1)+1.
  - LOCK_COUNT ≥ 1 and MISS_LIMIT ≥ 1.

Test Plan:
Bench parameters: PERIOD_LEN=100, TOLERANCE=2, LOCK_COUNT=3, MISS_LIMIT=2, tvalid continuously high unless stated.
- Acquisition: peaks at samples 10, 110, 210.
  - state_o goes 0→1 after sample 10 and →2 after sample 210; locked_o rises after sample 210.
  - ssb_start_o pulses at sample 310; no offset_valid_o pulse before sample 310.
- Offset tracking: after lock, a peak at sample 312 gives timing_offset_o=+2 with an offset_valid_o pulse. A next peak at 410 gives −2; a next peak at 512 gives +2.
- Out-of-window rejection: while VERIFY after a peak at 10, a peak at 50 has no effect. A peak at 113 is outside the window, so the window closes at sample 112 and state returns to SEARCH. The peak at 113 is then evaluated in SEARCH and restarts acquisition (state goes to VERIFY).
- Loss of lock: after lock at 210, no further peaks.
  - ssb_start_o pulses at samples 310 and 410.
  - misses reaches 2 at window close (sample 412); locked_o falls and state_o=0 after sample 412.
- Gapped input and reset: repeat acquisition with tvalid low every other cycle; lock is reached after exactly the same number of valid samples. Then asserting reset_i for one cycle mid-LOCKED clears all outputs on the next edge, and enable_i low behaves identically.
